// File: rtl/led_dc.sv
// LED display driver: serial gray-level loader into a double-buffered frame
// store, and a per-scanline PWM engine driving CH constant-current outputs.
// Word n of a frame belongs to scanline n/CH, channel n%CH.
// CH and LINES are expected to be powers of two.
module led_dc #(
  parameter int CH    = 16,
  parameter int LINES = 32,
  parameter int GW    = 16
) (
  input  logic          GCK,
  input  logic          rst,
  input  logic          DCK,
  input  logic          DAI,
  input  logic          DEN,
  input  logic          Vsync,
  input  logic          mode,
  output logic [CH-1:0] OUT
);

  localparam int CW    = $clog2(CH);
  localparam int LW    = $clog2(LINES);
  localparam int AW    = CW + LW;
  localparam int BW    = $clog2(GW);
  localparam int WORDS = CH * LINES;

  // mode is reserved and has no functional effect
  logic mode_unused;
  assign mode_unused = mode;

  // serial input synchronizers
  logic [2:0] dck_sync;
  logic [1:0] dai_sync;
  logic [1:0] den_sync;
  logic       den_prev;

  logic dck_rise;
  logic dai_s;
  logic den_s;
  logic den_low2;

  // frame loader state
  logic [GW-1:0] shift;
  logic [BW-1:0] bit_cnt;
  logic [AW-1:0] word_cnt;
  logic          wr_bank;
  logic          pending;
  logic          frame_valid;
  logic [GW-1:0] next_word;
  logic          word_done;

  // two banks of one frame each; the bank is the top address bit
  logic [GW-1:0] store [0:2*WORDS-1];

  // scanline / display state
  logic          vsync_d;
  logic [LW-1:0] line;
  logic          disp_bank;
  logic          shown;
  logic          v_rise;
  logic          v_fall;
  logic          take_first;
  logic          rd_bank;
  logic [GW-1:0] gray [CH];
  logic [GW-1:0] cnt;

  // DCK, DAI and DEN share the same two-flop depth; dck_sync[2] is the previous sample for edge detection
  always_ff @(posedge GCK) begin
    if (rst) begin
      dck_sync <= '0;
      dai_sync <= '0;
      den_sync <= '0;
      den_prev <= 1'b0;
    end else begin
      dck_sync <= {dck_sync[1:0], DCK};
      dai_sync <= {dai_sync[0], DAI};
      den_sync <= {den_sync[0], DEN};
      den_prev <= den_sync[1];
    end
  end

  assign dck_rise  = dck_sync[1] & ~dck_sync[2];
  assign dai_s     = dai_sync[1];
  assign den_s     = den_sync[1];
  assign den_low2  = ~den_s & ~den_prev;
  assign next_word = {dai_s, shift[GW-1:1]};
  assign word_done = dck_rise & den_s & (bit_cnt == BW'(GW - 1));

  // shift bits in LSB first, count words and flip banks when a frame completes
  always_ff @(posedge GCK) begin
    if (rst) begin
      shift       <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      wr_bank     <= 1'b0;
      pending     <= 1'b0;
      frame_valid <= 1'b0;
    end else if (dck_rise) begin
      if (den_s) begin
        shift <= next_word;
        if (bit_cnt == BW'(GW - 1)) begin
          bit_cnt  <= '0;
          word_cnt <= word_cnt + 1'b1;
          if (word_cnt == AW'(WORDS - 1)) begin
            wr_bank     <= ~wr_bank;
            pending     <= wr_bank;
            frame_valid <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        bit_cnt <= '0;
      end
    end else if (den_low2) begin
      bit_cnt <= '0;
    end
  end

  // frame store write port; contents deliberately survive reset
  always_ff @(posedge GCK) begin
    if (!rst && word_done) begin
      store[{wr_bank, word_cnt}] <= next_word;
    end
  end

  assign v_rise     = Vsync & ~vsync_d;
  assign v_fall     = ~Vsync & vsync_d;
  assign take_first = v_rise & frame_valid & ~shown & (line == '0);
  assign rd_bank    = take_first ? pending : disp_bank;

  // scanline advance on Vsync fall; display bank follows the pending bank on wrap or first start
  always_ff @(posedge GCK) begin
    if (rst) begin
      vsync_d   <= 1'b0;
      line      <= '0;
      disp_bank <= 1'b0;
      shown     <= 1'b0;
    end else begin
      vsync_d <= Vsync;
      if (take_first) begin
        disp_bank <= pending;
        shown     <= 1'b1;
      end
      if (v_fall) begin
        if (line == LW'(LINES - 1)) begin
          line      <= '0;
          disp_bank <= pending;
          shown     <= shown | frame_valid;
        end else begin
          line <= line + 1'b1;
        end
      end
    end
  end

  // fetch the gray levels of the current scanline from the display bank
  always_comb begin
    for (int z = 0; z < CH; z++) begin
      gray[z] = store[{rd_bank, line, CW'(z)}];
    end
  end

  // PWM: each channel is high while the window counter is below its gray level
  always_ff @(posedge GCK) begin
    if (rst || !Vsync) begin
      cnt <= '0;
      OUT <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      for (int z = 0; z < CH; z++) begin
        OUT[z] <= frame_valid & (cnt < gray[z]);
      end
    end
  end

endmodule

// File: tb/tb_led_dc.sv
// Self-checking bench for led_dc, run with a reduced geometry so full PWM
// windows and frames fit a short simulation. A frame-level model tracks
// which loaded frame should be on screen and how many high samples each
// channel owes per scanline window.
module tb_led_dc;

  localparam int CH       = 16;
  localparam int LINES    = 4;
  localparam int GW       = 8;
  localparam int WORDS    = CH * LINES;
  localparam int WIN      = 1 << GW;
  localparam int DCK_HALF = 4;

  logic          GCK = 1'b0;
  logic          rst;
  logic          DCK;
  logic          DAI;
  logic          DEN;
  logic          Vsync;
  logic          mode;
  logic [CH-1:0] OUT;

  int errors = 0;
  int checks = 0;

  // frame-level reference model
  int frame      [WORDS];
  int shown_f    [WORDS];
  int latest_f   [WORDS];
  bit m_valid;
  int m_line;
  int counts     [CH];
  int expect_cnt [CH];

  led_dc #(.CH(CH), .LINES(LINES), .GW(GW)) dut (
    .GCK  (GCK),
    .rst  (rst),
    .DCK  (DCK),
    .DAI  (DAI),
    .DEN  (DEN),
    .Vsync(Vsync),
    .mode (mode),
    .OUT  (OUT)
  );

  always #5 GCK = ~GCK;

  task automatic tick(input int n);
    repeat (n) @(negedge GCK);
  endtask

  task automatic do_reset();
    @(negedge GCK);
    rst   = 1'b1;
    Vsync = 1'b0;
    DCK   = 1'b0;
    DAI   = 1'b0;
    DEN   = 1'b0;
    tick(3);
    rst     = 1'b0;
    m_valid = 1'b0;
    m_line  = 0;
  endtask

  task automatic send_bit(input bit b);
    DAI = b;
    DEN = 1'b1;
    DCK = 1'b0;
    tick(DCK_HALF);
    DCK = 1'b1;
    tick(DCK_HALF);
  endtask

  task automatic send_word(input int w);
    for (int i = 0; i < GW; i++) send_bit(w[i]);
  endtask

  // load the whole frame[] array, then record it as the newest complete frame
  task automatic send_frame();
    for (int n = 0; n < WORDS; n++) send_word(frame[n]);
    DCK = 1'b0;
    DEN = 1'b0;
    tick(8);
    if (!m_valid) shown_f = frame;
    latest_f = frame;
    m_valid  = 1'b1;
  endtask

  task automatic random_frame();
    for (int n = 0; n < WORDS; n++) frame[n] = int'($urandom_range(0, WIN - 1));
  endtask

  // one Vsync window of WIN edges followed by a low gap; counts high samples per channel
  task automatic run_line(input int gap);
    for (int z = 0; z < CH; z++) begin
      counts[z]     = 0;
      expect_cnt[z] = m_valid ? shown_f[m_line * CH + z] : 0;
    end
    @(negedge GCK);
    Vsync = 1'b1;
    for (int k = 0; k < WIN; k++) begin
      @(posedge GCK);
      #1;
      for (int z = 0; z < CH; z++) counts[z] += int'(OUT[z]);
    end
    @(negedge GCK);
    Vsync = 1'b0;
    tick(gap);
    m_line++;
    if (m_line == LINES) begin
      m_line = 0;
      if (m_valid) shown_f = latest_f;
    end
  endtask

  task automatic test_reset();
    @(negedge GCK);
    rst   = 1'b1;
    Vsync = 1'b1;
    DCK   = 1'b0;
    DEN   = 1'b0;
    DAI   = 1'b0;
    for (int z = 0; z < CH; z++) counts[z] = 0;
    for (int k = 0; k < WIN; k++) begin
      @(posedge GCK);
      #1;
      for (int z = 0; z < CH; z++) counts[z] += int'(OUT[z]);
    end
    for (int z = 0; z < CH; z++) begin
      checks++;
      if (counts[z] !== 0) begin
        errors++;
        $display("[TB] FAIL reset_hold ch%0d: high samples %0d, required 0", z, counts[z]);
      end
    end
    do_reset();
    @(posedge GCK);
    #1;
    checks++;
    if (OUT !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out: OUT %h, required 0", OUT);
    end
    run_line(3);
    for (int z = 0; z < CH; z++) begin
      checks++;
      if (counts[z] !== expect_cnt[z]) begin
        errors++;
        $display("[TB] FAIL no_frame ch%0d: high samples %0d, required %0d", z, counts[z], expect_cnt[z]);
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int n = 0; n < WORDS; n++) frame[n] = 0;
    frame[0]      = 1;
    frame[CH - 1] = WIN - 1;
    send_frame();
    run_line(3);
    for (int z = 0; z < CH; z++) begin
      checks++;
      if (counts[z] !== expect_cnt[z]) begin
        errors++;
        $display("[TB] FAIL extremes ch%0d: high samples %0d, required %0d", z, counts[z], expect_cnt[z]);
      end
    end
  endtask

  task automatic test_ramp();
    do_reset();
    for (int n = 0; n < WORDS; n++) frame[n] = n * (WIN / WORDS);
    send_frame();
    for (int l = 0; l <= LINES; l++) begin
      run_line(3);
      for (int z = 0; z < CH; z++) begin
        checks++;
        if (counts[z] !== expect_cnt[z]) begin
          errors++;
          $display("[TB] FAIL ramp step%0d ch%0d: high samples %0d, required %0d", l, z, counts[z], expect_cnt[z]);
        end
      end
    end
  endtask

  task automatic test_double_buffer();
    do_reset();
    random_frame();
    frame[5] = WIN - 1;
    send_frame();
    for (int l = 0; l < 2; l++) run_line(3);
    random_frame();
    frame[2 * CH + 1] = 0;
    send_frame();
    for (int l = 0; l < LINES; l++) begin
      run_line(3);
      for (int z = 0; z < CH; z++) begin
        checks++;
        if (counts[z] !== expect_cnt[z]) begin
          errors++;
          $display("[TB] FAIL dbuf step%0d ch%0d: high samples %0d, required %0d", l, z, counts[z], expect_cnt[z]);
        end
      end
    end
  endtask

  task automatic test_partial_word();
    do_reset();
    for (int i = 0; i < GW / 2 + 1; i++) send_bit(1'($urandom_range(0, 1)));
    DCK = 1'b0;
    DEN = 1'b0;
    tick(6);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    DEN = 1'b0;
    DCK = 1'b0;
    tick(DCK_HALF);
    DCK = 1'b1;
    tick(DCK_HALF);
    random_frame();
    send_frame();
    for (int l = 0; l < 2; l++) begin
      run_line(3);
      for (int z = 0; z < CH; z++) begin
        checks++;
        if (counts[z] !== expect_cnt[z]) begin
          errors++;
          $display("[TB] FAIL partial step%0d ch%0d: high samples %0d, required %0d", l, z, counts[z], expect_cnt[z]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    random_frame();
    send_frame();
    run_line(3);
    @(negedge GCK);
    Vsync = 1'b1;
    tick(100);
    rst = 1'b1;
    @(posedge GCK);
    #1;
    checks++;
    if (OUT !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_out: OUT %h, required 0", OUT);
    end
    tick(3);
    rst     = 1'b0;
    Vsync   = 1'b0;
    m_valid = 1'b0;
    m_line  = 0;
    tick(3);
    run_line(3);
    for (int z = 0; z < CH; z++) begin
      checks++;
      if (counts[z] !== expect_cnt[z]) begin
        errors++;
        $display("[TB] FAIL invalid_after_reset ch%0d: high samples %0d, required %0d", z, counts[z], expect_cnt[z]);
      end
    end
    random_frame();
    send_frame();
    for (int l = 0; l < 2; l++) begin
      run_line(3);
      for (int z = 0; z < CH; z++) begin
        checks++;
        if (counts[z] !== expect_cnt[z]) begin
          errors++;
          $display("[TB] FAIL reload step%0d ch%0d: high samples %0d, required %0d", l, z, counts[z], expect_cnt[z]);
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    DCK   = 1'b0;
    DAI   = 1'b0;
    DEN   = 1'b0;
    Vsync = 1'b0;
    mode  = 1'b0;
    test_reset();
    test_extremes();
    test_ramp();
    test_double_buffer();
    test_partial_word();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
